// File: rtl/ssi_pkg.sv
// Shared SSI definitions used by both the DC7 master and the DB7 responder:
// FSM state encoding, address field positions and the default frame length.
package ssi_pkg;

    typedef enum logic [1:0] {
        stIDLE   = 2'd0,
        stDECODE = 2'd1,
        stACK    = 2'd2,
        stDONE   = 2'd3
    } ssi_state_t;

    localparam int ADDR_READ_BIT  = 7;
    localparam int ADDR_ID_MSB    = 6;
    localparam int ADDR_ID_LSB    = 4;
    localparam int ADDR_REG_MSB   = 3;
    localparam int SSI_FRAME_BITS = 16;

endpackage

// File: rtl/ssi_sync_edge.sv
// N-stage synchroniser for one asynchronous SSI input, with rise/fall
// detection on the synchronised value.
module ssi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_sr;
    logic              q_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_sr <= '0;
            q_d     <= 1'b0;
        end else begin
            sync_sr <= {sync_sr[STAGES-2:0], d};
            q_d     <= sync_sr[STAGES-1];
        end
    end

    assign q    = sync_sr[STAGES-1];
    assign rise = q & ~q_d;
    assign fall = ~q & q_d;

endmodule

// File: rtl/ssi_responder.sv
// DB7-side SSI responder: deserialises, decodes and acknowledges frames from
// the DC7 master. Define SSI_READBACK_EN to add read frames and the SSDIn port.
module ssi_responder
    import ssi_pkg::*;
#(
    parameter logic [2:0] DEVICE_ID   = 3'b010,
    parameter int         SYNC_STAGES = 2,
    parameter int         ACK_CYCLES  = 8,
    parameter int         FRAME_BITS  = SSI_FRAME_BITS
) (
    input  logic        PCI_Clock,
    input  logic        PCI_Reset,
    input  logic        SSClock,
    input  logic        SSAddr,
    input  logic        SSDOut,
    input  logic        SSStrobe,
    output logic        SSAck,
    output logic        WrValid,
    output logic [3:0]  WrAddr,
    output logic [15:0] WrData,
    output logic        RdReq,
    output logic [3:0]  RdAddr,
    input  logic [15:0] RdData,
    output logic        FrameError
`ifdef SSI_READBACK_EN
   ,output logic        SSDIn
`endif
);

    logic clk_q, clk_rise, clk_fall;
    logic addr_q, addr_rise, addr_fall;
    logic dout_q, dout_rise, dout_fall;
    logic strb_q, strb_rise, strb_fall;

    ssi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
        .clk(PCI_Clock), .rst(PCI_Reset), .d(SSClock),
        .q(clk_q), .rise(clk_rise), .fall(clk_fall));
    ssi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_addr (
        .clk(PCI_Clock), .rst(PCI_Reset), .d(SSAddr),
        .q(addr_q), .rise(addr_rise), .fall(addr_fall));
    ssi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_dout (
        .clk(PCI_Clock), .rst(PCI_Reset), .d(SSDOut),
        .q(dout_q), .rise(dout_rise), .fall(dout_fall));
    ssi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_strb (
        .clk(PCI_Clock), .rst(PCI_Reset), .d(SSStrobe),
        .q(strb_q), .rise(strb_rise), .fall(strb_fall));

    ssi_state_t  state, state_n;
    logic [7:0]  addr_sr, addr_sr_n;
    logic [15:0] data_sr, data_sr_n;
    logic [4:0]  bitcnt, bitcnt_n;
    logic [7:0]  ack_cnt, ack_cnt_n;
    logic        ack_n, wr_valid_n, frame_err_n;
    logic [3:0]  wr_addr_n;
    logic [15:0] wr_data_n;

`ifdef SSI_READBACK_EN
    logic [15:0] out_sr, out_sr_n;
    logic        rd_req_n, rd_cap;
    logic [3:0]  rd_addr_n;
    logic        unused_sync;
    assign unused_sync = ^{clk_q, addr_rise, addr_fall, dout_rise, dout_fall, strb_fall};
`else
    logic        unused_sync;
    assign unused_sync = ^{clk_q, clk_fall, addr_rise, addr_fall, dout_rise, dout_fall,
                           strb_fall, RdData};
    assign RdReq  = 1'b0;
    assign RdAddr = '0;
`endif

    always_comb begin
        state_n     = state;
        addr_sr_n   = addr_sr;
        data_sr_n   = data_sr;
        bitcnt_n    = bitcnt;
        ack_cnt_n   = ack_cnt;
        ack_n       = 1'b0;
        wr_valid_n  = 1'b0;
        frame_err_n = 1'b0;
        wr_addr_n   = WrAddr;
        wr_data_n   = WrData;
`ifdef SSI_READBACK_EN
        out_sr_n    = out_sr;
        rd_req_n    = 1'b0;
        rd_addr_n   = RdAddr;
        if (rd_cap)
            out_sr_n = RdData;
`endif
        unique case (state)
            stIDLE: begin
                if (clk_rise) begin
                    addr_sr_n = {addr_sr[6:0], addr_q};
                    data_sr_n = {data_sr[14:0], dout_q};
                    if (bitcnt != 5'd31)
                        bitcnt_n = bitcnt + 5'd1;
                end
`ifdef SSI_READBACK_EN
                if (clk_fall)
                    out_sr_n = {out_sr[14:0], 1'b0};
`endif
                if (strb_rise)
                    state_n = stDECODE;
            end
            stDECODE: begin
                ack_cnt_n = '0;
                state_n   = stDONE;
                if (bitcnt != 5'(FRAME_BITS)) begin
                    frame_err_n = 1'b1;
                end else if (addr_sr[ADDR_ID_MSB:ADDR_ID_LSB] != DEVICE_ID) begin
                    state_n = stDONE;
                end else if (!addr_sr[ADDR_READ_BIT]) begin
                    wr_valid_n = 1'b1;
                    wr_addr_n  = addr_sr[ADDR_REG_MSB:0];
                    wr_data_n  = data_sr;
                    state_n    = stACK;
`ifdef SSI_READBACK_EN
                    out_sr_n   = '0;
`endif
                end else begin
`ifdef SSI_READBACK_EN
                    rd_req_n  = 1'b1;
                    rd_addr_n = addr_sr[ADDR_REG_MSB:0];
                    state_n   = stACK;
`endif
                end
            end
            stACK: begin
                // SSAck is registered, so it trails the state by one cycle
                // but still spans exactly ACK_CYCLES cycles.
                ack_n = 1'b1;
                if (ack_cnt == 8'(ACK_CYCLES - 1))
                    state_n = stDONE;
                else
                    ack_cnt_n = ack_cnt + 8'd1;
            end
            stDONE: begin
                bitcnt_n  = '0;
                addr_sr_n = '0;
                data_sr_n = '0;
                if (!strb_q)
                    state_n = stIDLE;
            end
            default: state_n = stIDLE;
        endcase
    end

    always_ff @(posedge PCI_Clock or posedge PCI_Reset) begin
        if (PCI_Reset) begin
            state      <= stIDLE;
            addr_sr    <= '0;
            data_sr    <= '0;
            bitcnt     <= '0;
            ack_cnt    <= '0;
            SSAck      <= 1'b0;
            WrValid    <= 1'b0;
            WrAddr     <= '0;
            WrData     <= '0;
            FrameError <= 1'b0;
        end else begin
            state      <= state_n;
            addr_sr    <= addr_sr_n;
            data_sr    <= data_sr_n;
            bitcnt     <= bitcnt_n;
            ack_cnt    <= ack_cnt_n;
            SSAck      <= ack_n;
            WrValid    <= wr_valid_n;
            WrAddr     <= wr_addr_n;
            WrData     <= wr_data_n;
            FrameError <= frame_err_n;
        end
    end

`ifdef SSI_READBACK_EN
    always_ff @(posedge PCI_Clock or posedge PCI_Reset) begin
        if (PCI_Reset) begin
            out_sr <= '0;
            RdReq  <= 1'b0;
            RdAddr <= '0;
            rd_cap <= 1'b0;
        end else begin
            out_sr <= out_sr_n;
            RdReq  <= rd_req_n;
            RdAddr <= rd_addr_n;
            rd_cap <= RdReq;
        end
    end

    assign SSDIn = out_sr[15];
`endif

endmodule
